// File: rtl/id_exe_stage.sv
// ID/EX pipeline register with load-use hazard detection and EX-side operand forwarding.
// Optional performance counters are enabled by defining IDEX_PERF_CNT_EN.
module id_exe_stage #(
    parameter int WORD_LEN     = 32,
    parameter int CMD_LEN      = 4,
    parameter int REG_ADDR_LEN = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    hold,
    input  logic                    flush,
    input  logic                    id_valid,
    input  logic [WORD_LEN-1:0]     id_val1,
    input  logic [WORD_LEN-1:0]     id_val2,
    input  logic [REG_ADDR_LEN-1:0] id_src1,
    input  logic [REG_ADDR_LEN-1:0] id_src2,
    input  logic                    id_uses_src2,
    input  logic [WORD_LEN-1:0]     id_imm,
    input  logic                    id_imm_sel,
    input  logic [CMD_LEN-1:0]      id_exe_cmd,
    input  logic [REG_ADDR_LEN-1:0] id_dest,
    input  logic                    id_wb_en,
    input  logic                    id_mem_read,
    input  logic                    id_mem_write,
    input  logic                    mem_wb_en,
    input  logic [REG_ADDR_LEN-1:0] mem_dest,
    input  logic [WORD_LEN-1:0]     mem_result,
    input  logic                    wb_wb_en,
    input  logic [REG_ADDR_LEN-1:0] wb_dest,
    input  logic [WORD_LEN-1:0]     wb_result,
    output logic                    hazard_stall,
    output logic                    ex_valid,
    output logic [WORD_LEN-1:0]     ex_val1,
    output logic [WORD_LEN-1:0]     ex_val2,
    output logic [CMD_LEN-1:0]      ex_exe_cmd,
    output logic [WORD_LEN-1:0]     ex_st_val,
    output logic [REG_ADDR_LEN-1:0] ex_dest,
    output logic                    ex_wb_en,
    output logic                    ex_mem_read,
    output logic                    ex_mem_write
`ifdef IDEX_PERF_CNT_EN
    ,
    output logic [WORD_LEN-1:0]     perf_bubble_cnt,
    output logic [WORD_LEN-1:0]     perf_hold_cnt
`endif
);

    logic                    valid_q,     valid_d;
    logic [WORD_LEN-1:0]     val1_q,      val1_d;
    logic [WORD_LEN-1:0]     val2_q,      val2_d;
    logic [REG_ADDR_LEN-1:0] src1_q,      src1_d;
    logic [REG_ADDR_LEN-1:0] src2_q,      src2_d;
    logic [WORD_LEN-1:0]     imm_q,       imm_d;
    logic                    imm_sel_q,   imm_sel_d;
    logic [CMD_LEN-1:0]      exe_cmd_q,   exe_cmd_d;
    logic [REG_ADDR_LEN-1:0] dest_q,      dest_d;
    logic                    wb_en_q,     wb_en_d;
    logic                    mem_read_q,  mem_read_d;
    logic                    mem_write_q, mem_write_d;

    logic                    load_bubble;
    logic                    capture;
    logic [WORD_LEN-1:0]     fwd1;
    logic [WORD_LEN-1:0]     fwd2;

    // A load in EX whose target is read by the instruction in ID needs one bubble.
    always_comb begin
        hazard_stall = ~hold & valid_q & mem_read_q & (dest_q != '0) & id_valid &
                       ((dest_q == id_src1) | (id_uses_src2 & (dest_q == id_src2)));
    end

    always_comb begin
        load_bubble = flush | (~hold & hazard_stall);
        capture     = ~flush & ~hold & ~hazard_stall;
    end

    always_comb begin
        valid_d     = valid_q;
        val1_d      = val1_q;
        val2_d      = val2_q;
        src1_d      = src1_q;
        src2_d      = src2_q;
        imm_d       = imm_q;
        imm_sel_d   = imm_sel_q;
        exe_cmd_d   = exe_cmd_q;
        dest_d      = dest_q;
        wb_en_d     = wb_en_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        if (load_bubble) begin
            valid_d     = 1'b0;
            val1_d      = '0;
            val2_d      = '0;
            src1_d      = '0;
            src2_d      = '0;
            imm_d       = '0;
            imm_sel_d   = 1'b0;
            exe_cmd_d   = '0;
            dest_d      = '0;
            wb_en_d     = 1'b0;
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
        end else if (capture) begin
            valid_d     = id_valid;
            val1_d      = id_val1;
            val2_d      = id_val2;
            src1_d      = id_src1;
            src2_d      = id_src2;
            imm_d       = id_imm;
            imm_sel_d   = id_imm_sel;
            exe_cmd_d   = id_exe_cmd;
            dest_d      = id_dest;
            wb_en_d     = id_wb_en;
            mem_read_d  = id_mem_read;
            mem_write_d = id_mem_write;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            val1_q      <= '0;
            val2_q      <= '0;
            src1_q      <= '0;
            src2_q      <= '0;
            imm_q       <= '0;
            imm_sel_q   <= 1'b0;
            exe_cmd_q   <= '0;
            dest_q      <= '0;
            wb_en_q     <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            val1_q      <= val1_d;
            val2_q      <= val2_d;
            src1_q      <= src1_d;
            src2_q      <= src2_d;
            imm_q       <= imm_d;
            imm_sel_q   <= imm_sel_d;
            exe_cmd_q   <= exe_cmd_d;
            dest_q      <= dest_d;
            wb_en_q     <= wb_en_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
        end
    end

    // EX/MEM wins over MEM/WB since it carries the newer value; r0 is never forwarded.
    function automatic logic [WORD_LEN-1:0] fwd_sel(
        input logic [REG_ADDR_LEN-1:0] src,
        input logic [WORD_LEN-1:0]     reg_val
    );
        if (mem_wb_en && (mem_dest != '0) && (mem_dest == src))
            return mem_result;
        else if (wb_wb_en && (wb_dest != '0) && (wb_dest == src))
            return wb_result;
        else
            return reg_val;
    endfunction

    always_comb begin
        fwd1 = fwd_sel(src1_q, val1_q);
        fwd2 = fwd_sel(src2_q, val2_q);
    end

    // Shift amounts pass through val2 untouched; the ALU decides how many bits matter.
    always_comb begin
        ex_valid     = valid_q;
        ex_val1      = fwd1;
        ex_val2      = imm_sel_q ? imm_q : fwd2;
        ex_st_val    = fwd2;
        ex_exe_cmd   = exe_cmd_q;
        ex_dest      = dest_q;
        ex_wb_en     = wb_en_q;
        ex_mem_read  = mem_read_q;
        ex_mem_write = mem_write_q;
    end

`ifdef IDEX_PERF_CNT_EN
    logic [WORD_LEN-1:0] bubble_cnt_q, bubble_cnt_d;
    logic [WORD_LEN-1:0] hold_cnt_q,   hold_cnt_d;

    always_comb begin
        bubble_cnt_d = load_bubble ? bubble_cnt_q + 1'b1 : bubble_cnt_q;
        hold_cnt_d   = hold        ? hold_cnt_q + 1'b1   : hold_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt_q <= '0;
            hold_cnt_q   <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
        end
    end

    always_comb begin
        perf_bubble_cnt = bubble_cnt_q;
        perf_hold_cnt   = hold_cnt_q;
    end
`endif

endmodule

// File: doc/id_exe_stage.md
Name: id_exe_stage

Overview:
- ID/EX pipeline stage of the MIPS pipelined CPU, sitting directly upstream of the ALU.
- Registers decoded operands and control, then drives the ALU's val1/val2/EXE_CMD through EX-stage forwarding muxes.
- Detects load-use hazards, inserts bubbles and requests an IF/ID stall.
- Handles branch flush and global pipeline hold.

Parameters:
- WORD_LEN, 32, datapath width.
- CMD_LEN, 4, EXE_CMD width; must match the ALU's EXE_CMD_LEN.
- REG_ADDR_LEN, 5, register-file address width.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- hold  in  1  global pipeline freeze; asserted to all stages simultaneously.
- flush  in  1  branch taken; kill the instruction entering EX.
- id_valid  in  1  ID holds a real instruction.
- id_val1, id_val2  in  WORD_LEN  register-file read data for rs, rt.
- id_src1, id_src2  in  REG_ADDR_LEN  rs, rt addresses.
- id_uses_src2  in  1  instruction reads rt (R-type, store, branch).
- id_imm  in  WORD_LEN  sign/zero-extended immediate.
- id_imm_sel  in  1  ALU val2 takes the immediate.
- id_exe_cmd  in  CMD_LEN  ALU command.
- id_dest  in  REG_ADDR_LEN  write-back register.
- id_wb_en, id_mem_read, id_mem_write  in  1  control bits.
- mem_wb_en  in  1  EX/MEM write-back enable.
- mem_dest  in  REG_ADDR_LEN  EX/MEM destination.
- mem_result  in  WORD_LEN  EX/MEM result.
- wb_wb_en  in  1  MEM/WB write-back enable.
- wb_dest  in  REG_ADDR_LEN  MEM/WB destination.
- wb_result  in  WORD_LEN  MEM/WB result.
- hazard_stall  out  1  combinational; IF/ID must hold this cycle.
- ex_valid  out  1  EX holds a real instruction.
- ex_val1, ex_val2  out  WORD_LEN  ALU operands.
- ex_exe_cmd  out  CMD_LEN  ALU command.
- ex_st_val  out  WORD_LEN  forwarded rt value for stores.
- ex_dest  out  REG_ADDR_LEN  write-back register.
- ex_wb_en, ex_mem_read, ex_mem_write  out  1  control bits.

Behaviour:
- Reset: rst_n low asynchronously clears every stage register to 0 (valid, data, addresses, cmd, control).
  - With all registers 0, ex_val1/ex_val2/ex_st_val read 0 and hazard_stall reads 0.
  - Reset asserted mid-stall drops the stall immediately.
- Register update priority on each rising edge:
  1. flush: load a bubble.
  2. hold: keep all registers unchanged.
  3. hazard_stall: load a bubble.
  4. Otherwise: capture the id_* inputs.
- Bubble definition: valid=0, wb_en=0, mem_read=0, mem_write=0, exe_cmd=0, dest=0; data fields are don't-care but are driven to 0.
- When flush and hazard_stall occur together, the result is a bubble; hazard_stall still asserts so that ID holds.
- Hazard detection:
  - hazard_stall = ex_valid & ex_mem_read & (ex_dest!=0) & id_valid & ((ex_dest==id_src1) | (id_uses_src2 & (ex_dest==id_src2))).
  - It is forced to 0 while hold=1.
  - Latency: exactly one bubble per load-use pair, after which forwarding from MEM/WB resolves the dependency.
- Forwarding (combinational, evaluated on the registered src addresses):
  - Operand 1: if mem_wb_en & mem_dest!=0 & mem_dest==src1, take mem_result.
  - Else if wb_wb_en & wb_dest!=0 & wb_dest==src1, take wb_result.
  - Else take the registered val1.
  - EX/MEM has priority over MEM/WB, because it is the newer value.
  - Register 0 is never forwarded.
  - The same rule produces fwd2 from src2.
- Operand outputs:
  - ex_val1 = fwd1.
  - ex_val2 = imm_sel ? imm : fwd2.
  - ex_st_val = fwd2.
- Shift commands: EXE_SLL and EXE_SRL take the shift amount from val2 unmodified. This stage performs no masking; the ALU owns shift-amount width.
- Zero added latency: outputs are valid in the same cycle as the registers.

Optional Feature:
- Macro: IDEX_PERF_CNT_EN.
- When defined, two WORD_LEN output ports are added:
  - perf_bubble_cnt: increments on every edge where a bubble is loaded because of hazard_stall or flush.
  - perf_hold_cnt: increments on every edge with hold=1.
- Both counters wrap from all-ones to 0, reset asynchronously to 0, and are unaffected by flush.
- When undefined: the ports and counters are absent, and the block's other behaviour is identical.

Test Plan:
- Reset check: rst_n low mid-operation -> all ex_* outputs are 0 and hazard_stall=0 asynchronously, before the next clk edge.
- EX/MEM forwarding: ADD r3,r1,r2 with id_val1=5, id_val2=7, mem_wb_en=1, mem_dest=1, mem_result=100 -> ex_val1=100, ex_val2=7.
- Forwarding priority: mem_dest=wb_dest=2, mem_result=0xAA, wb_result=0xBB -> ex_val2=0xAA. With dest=0 on both sources -> the registered value passes through.
- Load-use: LW r4 in EX, then ADD r5,r4,r6 in ID -> hazard_stall=1 for one cycle and a bubble is loaded (ex_wb_en=0, ex_valid=0). Next cycle the ADD enters with ex_val1 forwarded from wb_result.
- Flush/hold: flush=1 with hold=1 -> bubble loaded. hold=1 alone for 3 cycles -> outputs unchanged and hazard_stall=0.
- Perf counters (IDEX_PERF_CNT_EN defined): 2 load-use stalls + 1 flush + 4 hold cycles -> perf_bubble_cnt=3, perf_hold_cnt=4.
